// File: rtl/axilite_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : axilite_slave_regfile
// Purpose  : AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers
//            with byte-strobe writes, SLVERR for out-of-range accesses and a
//            flat live view of every register.
// Ports    : s_axi_aclk / s_axi_aresetn  - clock, async active-low reset
//            s_axi_aw* / s_axi_w* / s_axi_b* - write address, data, response
//            s_axi_ar* / s_axi_r*          - read address, data
//            regs_o                        - live register contents,
//                                            register k at [32k+:32]
// Revision : 1.0 - initial release
// ============================================================================
module axilite_slave_regfile #(
   parameter int unsigned NUM_REGS    = 16,
   parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
   input  logic                     s_axi_aclk,
   input  logic                     s_axi_aresetn,
   // write address channel
   input  logic [31:0]              s_axi_awaddr,
   input  logic [2:0]               s_axi_awprot,
   input  logic                     s_axi_awvalid,
   output logic                     s_axi_awready,
   // write data channel
   input  logic [31:0]              s_axi_wdata,
   input  logic [3:0]               s_axi_wstrb,
   input  logic                     s_axi_wvalid,
   output logic                     s_axi_wready,
   // write response channel
   output logic [1:0]               s_axi_bresp,
   output logic                     s_axi_bvalid,
   input  logic                     s_axi_bready,
   // read address channel
   input  logic [31:0]              s_axi_araddr,
   input  logic [2:0]               s_axi_arprot,
   input  logic                     s_axi_arvalid,
   output logic                     s_axi_arready,
   // read data channel
   output logic [31:0]              s_axi_rdata,
   output logic [1:0]               s_axi_rresp,
   output logic                     s_axi_rvalid,
   input  logic                     s_axi_rready,
   // register contents
   output logic [32*NUM_REGS-1:0]   regs_o
);

   // A single register still needs a 1-bit index; the range check keeps it 0.
   localparam int unsigned IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [31:0] ADDR_LIMIT = 32'(4 * NUM_REGS);
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_RESP = 1'b1
   } wstate_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rstate_t;

   // ---------------------------------------------------------------------
   // Write side state
   // ---------------------------------------------------------------------
   wstate_t       wstate_q;
   logic          aw_held_q;
   logic          w_held_q;
   logic [31:0]   awaddr_q;
   logic [31:0]   wdata_q;
   logic [3:0]    wstrb_q;
   logic          bvalid_q;
   logic [1:0]    bresp_q;

   // ---------------------------------------------------------------------
   // Read side state
   // ---------------------------------------------------------------------
   rstate_t       rstate_q;
   logic          rvalid_q;
   logic [31:0]   rdata_q;
   logic [1:0]    rresp_q;

   // Protection bits carry no meaning for this block.
   logic          w_unused_ok;
   assign w_unused_ok = ^{s_axi_awprot, s_axi_arprot};

   // Readies come from registered state only, never from the valids.
   assign s_axi_awready = ~aw_held_q & (wstate_q == W_IDLE);
   assign s_axi_wready  = ~w_held_q  & (wstate_q == W_IDLE);
   assign s_axi_arready = (rstate_q == R_IDLE);

   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;

   logic aw_hs;
   logic w_hs;
   logic ar_hs;
   assign aw_hs = s_axi_awvalid & s_axi_awready;
   assign w_hs  = s_axi_wvalid  & s_axi_wready;
   assign ar_hs = s_axi_arvalid & s_axi_arready;

   // Commit fires on the edge that completes the second of AW/W (or both
   // together). Held halves come from the capture registers, fresh halves
   // straight from the bus.
   logic          commit;
   logic [31:0]   wr_addr;
   logic [31:0]   wr_data;
   logic [3:0]    wr_strb;
   logic          wr_in_range;
   logic [IDX_W-1:0] wr_idx;
   logic          wr_en;

   assign commit      = (aw_hs | aw_held_q) & (w_hs | w_held_q);
   assign wr_addr     = aw_held_q ? awaddr_q : s_axi_awaddr;
   assign wr_data     = w_held_q  ? wdata_q  : s_axi_wdata;
   assign wr_strb     = w_held_q  ? wstrb_q  : s_axi_wstrb;
   assign wr_in_range = (wr_addr < ADDR_LIMIT);
   assign wr_idx      = wr_addr[2 +: IDX_W];
   assign wr_en       = commit & wr_in_range;

   // ---------------------------------------------------------------------
   // Register array
   // ---------------------------------------------------------------------
   for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
      localparam logic [IDX_W-1:0] K_IDX = IDX_W'(k);
      logic [31:0] reg_q;

      always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
         if (!s_axi_aresetn) begin
            reg_q <= RESET_VALUE;
         end else if (wr_en && (wr_idx == K_IDX)) begin
            for (int b = 0; b < 4; b++) begin
               if (wr_strb[b]) begin
                  reg_q[8*b +: 8] <= wr_data[8*b +: 8];
               end
            end
         end
      end

      assign regs_o[32*k +: 32] = reg_q;
   end

   // ---------------------------------------------------------------------
   // Write FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         wstate_q  <= W_IDLE;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         awaddr_q  <= 32'h0;
         wdata_q   <= 32'h0;
         wstrb_q   <= 4'h0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         case (wstate_q)
            W_IDLE: begin
               if (commit) begin
                  aw_held_q <= 1'b0;
                  w_held_q  <= 1'b0;
                  bvalid_q  <= 1'b1;
                  bresp_q   <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
                  wstate_q  <= W_RESP;
               end else begin
                  if (aw_hs) begin
                     aw_held_q <= 1'b1;
                     awaddr_q  <= s_axi_awaddr;
                  end
                  if (w_hs) begin
                     w_held_q <= 1'b1;
                     wdata_q  <= s_axi_wdata;
                     wstrb_q  <= s_axi_wstrb;
                  end
               end
            end
            W_RESP: begin
               if (s_axi_bready) begin
                  bvalid_q <= 1'b0;
                  wstate_q <= W_IDLE;
               end
            end
            default: begin
               wstate_q <= W_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Read FSM
   // ---------------------------------------------------------------------
   logic                rd_in_range;
   logic [IDX_W-1:0]    rd_idx;
   logic [IDX_W+4:0]    rd_base;
   logic [31:0]         rd_word;

   assign rd_in_range = (s_axi_araddr < ADDR_LIMIT);
   assign rd_idx      = s_axi_araddr[2 +: IDX_W];
   assign rd_base     = {rd_idx, 5'b00000};
   // Sampled from the register outputs, so a same-edge commit is not seen.
   assign rd_word     = rd_in_range ? regs_o[rd_base +: 32] : 32'h0;

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         rstate_q <= R_IDLE;
         rvalid_q <= 1'b0;
         rdata_q  <= 32'h0;
         rresp_q  <= RESP_OKAY;
      end else begin
         case (rstate_q)
            R_IDLE: begin
               if (ar_hs) begin
                  rdata_q  <= rd_word;
                  rresp_q  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
                  rvalid_q <= 1'b1;
                  rstate_q <= R_DATA;
               end
            end
            R_DATA: begin
               if (s_axi_rready) begin
                  rvalid_q <= 1'b0;
                  rstate_q <= R_IDLE;
               end
            end
            default: begin
               rstate_q <= R_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axilite_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_axilite_slave_regfile
// Purpose  : Self-checking bench for axilite_slave_regfile against an
//            array-based register model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axilite_slave_regfile;

   localparam int          NREGS = 16;
   localparam logic [31:0] RSTV  = 32'h0000_0000;

   logic                 clk = 1'b0;
   logic                 aresetn = 1'b0;
   logic [31:0]          awaddr = '0;
   logic [2:0]           awprot = '0;
   logic                 awvalid = 1'b0;
   logic                 awready;
   logic [31:0]          wdata = '0;
   logic [3:0]           wstrb = '0;
   logic                 wvalid = 1'b0;
   logic                 wready;
   logic [1:0]           bresp;
   logic                 bvalid;
   logic                 bready = 1'b0;
   logic [31:0]          araddr = '0;
   logic [2:0]           arprot = '0;
   logic                 arvalid = 1'b0;
   logic                 arready;
   logic [31:0]          rdata;
   logic [1:0]           rresp;
   logic                 rvalid;
   logic                 rready = 1'b0;
   logic [32*NREGS-1:0]  regs;

   int total = 0;
   int bad   = 0;

   logic [31:0] model [NREGS];

   always #5 clk = ~clk;

   axilite_slave_regfile #(
      .NUM_REGS    (NREGS),
      .RESET_VALUE (RSTV)
   ) dut (
      .s_axi_aclk    (clk),
      .s_axi_aresetn (aresetn),
      .s_axi_awaddr  (awaddr),
      .s_axi_awprot  (awprot),
      .s_axi_awvalid (awvalid),
      .s_axi_awready (awready),
      .s_axi_wdata   (wdata),
      .s_axi_wstrb   (wstrb),
      .s_axi_wvalid  (wvalid),
      .s_axi_wready  (wready),
      .s_axi_bresp   (bresp),
      .s_axi_bvalid  (bvalid),
      .s_axi_bready  (bready),
      .s_axi_araddr  (araddr),
      .s_axi_arprot  (arprot),
      .s_axi_arvalid (arvalid),
      .s_axi_arready (arready),
      .s_axi_rdata   (rdata),
      .s_axi_rresp   (rresp),
      .s_axi_rvalid  (rvalid),
      .s_axi_rready  (rready),
      .regs_o        (regs)
   );

   // ---------------- reference model ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) model[i] = RSTV;
   endtask

   function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                              input logic [3:0] strb);
      int idx;
      if (addr >= 4 * NREGS) return 2'b10;
      idx = int'(addr / 4);
      for (int b = 0; b < 4; b++)
         if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
      return 2'b00;
   endfunction

   function automatic logic [31:0] model_rdata(input logic [31:0] addr);
      if (addr >= 4 * NREGS) return 32'h0;
      return model[int'(addr / 4)];
   endfunction

   function automatic logic [32*NREGS-1:0] model_vec();
      logic [32*NREGS-1:0] v;
      for (int i = 0; i < NREGS; i++) v[32*i +: 32] = model[i];
      return v;
   endfunction

   // ---------------- bus drivers ----------------
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp, output bit timeout);
      bit aw_pend;
      bit w_pend;
      bit hs_aw;
      bit hs_w;
      int n;
      aw_pend = 1; w_pend = 1; n = 0; timeout = 0; resp = 2'b11;
      awaddr = addr; wdata = data; wstrb = strb; bready = 1'b1;
      while ((aw_pend || w_pend) && n < 20) begin
         awvalid = aw_pend; wvalid = w_pend;
         hs_aw = aw_pend && awready;
         hs_w  = w_pend && wready;
         tick();
         if (hs_aw) aw_pend = 0;
         if (hs_w)  w_pend = 0;
         n++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      if (aw_pend || w_pend) timeout = 1;
      n = 0;
      while (!bvalid && n < 20) begin
         tick();
         n++;
      end
      if (!bvalid) timeout = 1;
      else begin
         resp = bresp;
         tick();
      end
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output bit timeout);
      int n;
      n = 0; timeout = 0; data = 32'hx; resp = 2'b11;
      araddr = addr; arvalid = 1'b1;
      while (!arready && n < 20) begin
         tick();
         n++;
      end
      tick();
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 20) begin
         tick();
         n++;
      end
      if (!rvalid) timeout = 1;
      else begin
         data = rdata;
         resp = rresp;
         rready = 1'b1;
         tick();
         rready = 1'b0;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      aresetn = 1'b0;
      #12;
      total++;
      if (bvalid !== 1'b0 || rvalid !== 1'b0 || bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 32'h0) begin
         bad++;
         $display("FAIL reset_outputs: bvalid=%b rvalid=%b bresp=%b rresp=%b rdata=%h, want all zero",
                  bvalid, rvalid, bresp, rresp, rdata);
      end
      total++;
      if ({awready, wready, arready} !== 3'b111) begin
         bad++;
         $display("FAIL reset_readies: got %b want 111", {awready, wready, arready});
      end
      model_reset();
      total++;
      if (regs !== model_vec()) begin
         bad++;
         $display("FAIL reset_regs: got %h want %h", regs, model_vec());
      end
      @(negedge clk);
      aresetn = 1'b1;
      tick();
   endtask

   task automatic test_same_cycle();
      awaddr = 32'h08; wdata = 32'hDEADBEEF; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      void'(model_write(32'h08, 32'hDEADBEEF, 4'hF));
      total++;
      if (bvalid !== 1'b1 || bresp !== 2'b00) begin
         bad++;
         $display("FAIL same_cycle_resp: bvalid=%b bresp=%b want 1/00", bvalid, bresp);
      end
      total++;
      if (regs[95:64] !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL same_cycle_reg2: got %h want DEADBEEF", regs[95:64]);
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      total++;
      if (bvalid !== 1'b0) begin
         bad++;
         $display("FAIL same_cycle_bdone: bvalid=%b want 0", bvalid);
      end
   endtask

   task automatic test_w_before_aw();
      bit wready_seen;
      bit bvalid_seen;
      wready_seen = 0; bvalid_seen = 0;
      wdata = 32'h000000AA; wstrb = 4'b0001; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      repeat (3) begin
         if (wready) wready_seen = 1;
         if (bvalid) bvalid_seen = 1;
         tick();
      end
      total++;
      if (wready_seen || bvalid_seen) begin
         bad++;
         $display("FAIL w_wait: wready_seen=%b bvalid_seen=%b want 0/0", wready_seen, bvalid_seen);
      end
      awaddr = 32'h08; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      void'(model_write(32'h08, 32'h000000AA, 4'b0001));
      total++;
      if (bvalid !== 1'b1 || bresp !== 2'b00) begin
         bad++;
         $display("FAIL w_first_resp: bvalid=%b bresp=%b want 1/00", bvalid, bresp);
      end
      total++;
      if (regs[95:64] !== model[2]) begin
         bad++;
         $display("FAIL w_first_reg2: got %h want %h", regs[95:64], model[2]);
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
   endtask

   task automatic test_out_of_range();
      logic [1:0]  r;
      logic [31:0] d;
      bit          to;
      axi_write(32'h40, 32'hCAFEF00D, 4'hF, r, to);
      total++;
      if (to || r !== 2'b10) begin
         bad++;
         $display("FAIL oor_write: bresp=%b timeout=%0d want 10/0", r, to);
      end
      total++;
      if (regs !== model_vec()) begin
         bad++;
         $display("FAIL oor_regs: got %h want %h", regs, model_vec());
      end
      axi_read(32'h40, d, r, to);
      total++;
      if (to || d !== 32'h0 || r !== 2'b10) begin
         bad++;
         $display("FAIL oor_read: rdata=%h rresp=%b timeout=%0d want 0/10/0", d, r, to);
      end
   endtask

   task automatic test_read_stall();
      logic [31:0] first;
      bit unstable;
      araddr = 32'h08; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      first = rdata;
      total++;
      if (rvalid !== 1'b1 || first !== model_rdata(32'h08)) begin
         bad++;
         $display("FAIL stall_first: rvalid=%b rdata=%h want 1/%h", rvalid, first, model_rdata(32'h08));
      end
      unstable = 0;
      repeat (5) begin
         if (rvalid !== 1'b1 || rdata !== first || rresp !== 2'b00 || arready !== 1'b0) unstable = 1;
         tick();
      end
      total++;
      if (unstable) begin
         bad++;
         $display("FAIL stall_hold: rvalid=%b rdata=%h arready=%b want stable 1/%h/0", rvalid, rdata, arready, first);
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
      total++;
      if (rvalid !== 1'b0 || arready !== 1'b1) begin
         bad++;
         $display("FAIL stall_release: rvalid=%b arready=%b want 0/1", rvalid, arready);
      end
   endtask

   task automatic test_read_during_write();
      logic [31:0] d;
      logic [1:0]  r;
      bit          to;
      logic [31:0] pre;
      pre = model_rdata(32'h0C);
      awaddr = 32'h0C; wdata = 32'h12345678; wstrb = 4'hF;
      araddr = 32'h0C;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      void'(model_write(32'h0C, 32'h12345678, 4'hF));
      total++;
      if (rvalid !== 1'b1 || rdata !== pre || bvalid !== 1'b1) begin
         bad++;
         $display("FAIL rw_same_edge: rvalid=%b rdata=%h bvalid=%b want 1/%h/1", rvalid, rdata, bvalid, pre);
      end
      bready = 1'b1; rready = 1'b1;
      tick();
      bready = 1'b0; rready = 1'b0;
      axi_read(32'h0C, d, r, to);
      total++;
      if (to || d !== 32'h12345678 || r !== 2'b00) begin
         bad++;
         $display("FAIL rw_followup: rdata=%h rresp=%b timeout=%0d want 12345678/00/0", d, r, to);
      end
   endtask

   task automatic test_reset_mid();
      bit bvalid_seen;
      awaddr = 32'h04; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      #2;
      aresetn = 1'b0;
      #1;
      model_reset();
      total++;
      if (bvalid !== 1'b0 || {awready, wready, arready} !== 3'b111) begin
         bad++;
         $display("FAIL midreset_ctrl: bvalid=%b readies=%b want 0/111", bvalid, {awready, wready, arready});
      end
      total++;
      if (regs !== model_vec()) begin
         bad++;
         $display("FAIL midreset_regs: got %h want %h", regs, model_vec());
      end
      @(negedge clk);
      aresetn = 1'b1;
      tick();
      wdata = 32'h55AA55AA; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
      tick();
      wvalid = 1'b0;
      bvalid_seen = 0;
      repeat (5) begin
         if (bvalid) bvalid_seen = 1;
         tick();
      end
      bready = 1'b0;
      total++;
      if (bvalid_seen || regs !== model_vec()) begin
         bad++;
         $display("FAIL midreset_w_alone: bvalid_seen=%b regs=%h want 0/%h", bvalid_seen, regs, model_vec());
      end
      // clear the lone held W
      aresetn = 1'b0;
      #3;
      @(negedge clk);
      aresetn = 1'b1;
      tick();
   endtask

   task automatic test_random();
      logic [31:0] a, d, rd;
      logic [3:0]  s;
      logic [1:0]  r, exp_r;
      bit          to;
      int          errs;
      errs = 0;
      for (int i = 0; i < 40; i++) begin
         a = $urandom_range(0, 4 * NREGS + 15);
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         axi_write(a, d, s, r, to);
         exp_r = model_write(a, d, s);
         total++;
         if (to || r !== exp_r) begin
            bad++;
            $display("FAIL rand_write[%0d]: addr=%h bresp=%b timeout=%0d want %b", i, a, r, to, exp_r);
         end
         a = $urandom_range(0, 4 * NREGS + 15);
         axi_read(a, rd, r, to);
         total++;
         if (to || rd !== model_rdata(a) || r !== ((a < 4 * NREGS) ? 2'b00 : 2'b10)) begin
            bad++;
            $display("FAIL rand_read[%0d]: addr=%h rdata=%h rresp=%b want %h", i, a, rd, r, model_rdata(a));
         end
      end
      total++;
      if (regs !== model_vec()) begin
         bad++;
         $display("FAIL rand_regs: got %h want %h", regs, model_vec());
      end
      if (errs != 0) $display("random phase had %0d issues", errs);
   endtask

   task automatic test_back_to_back();
      int cyc;
      int n;
      cyc = 0;
      bready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         awaddr = 32'(4 * (4 + i));
         wdata = $urandom;
         wstrb = 4'hF;
         awvalid = 1'b1; wvalid = 1'b1;
         n = 0;
         while (!(awready && wready) && n < 10) begin
            tick();
            n++;
            cyc++;
         end
         tick();
         cyc++;
         void'(model_write(awaddr, wdata, 4'hF));
      end
      awvalid = 1'b0; wvalid = 1'b0;
      tick();
      bready = 1'b0;
      total++;
      if (cyc > 7) begin
         bad++;
         $display("FAIL b2b_cycles: took %0d cycles want <= 7", cyc);
      end
      total++;
      if (regs !== model_vec()) begin
         bad++;
         $display("FAIL b2b_regs: got %h want %h", regs, model_vec());
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_same_cycle();
      test_w_before_aw();
      test_out_of_range();
      test_read_stall();
      test_read_during_write();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/axilite_slave_regfile.md
AXILITE_SLAVE_REGFILE -- requirements
Module: axilite_slave_regfile

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 16, meaning the number of 32-bit registers; legal values are 1..64.
REQ-002 The block SHALL have parameter RESET_VALUE, default 32'h0000_0000, meaning the value loaded into every register at reset.
REQ-003 The block SHALL have port s_axi_aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port s_axi_aresetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port s_axi_awaddr, input, 32 bits: write address, a byte offset relative to block base.
REQ-006 The block SHALL have ports s_axi_awvalid (input, 1), s_axi_awready (output, 1) and s_axi_awprot (input, 3); s_axi_awprot is accepted and ignored.
REQ-007 The block SHALL have ports s_axi_wdata (input, 32), s_axi_wstrb (input, 4), s_axi_wvalid (input, 1) and s_axi_wready (output, 1).
REQ-008 The block SHALL have ports s_axi_bresp (output, 2), s_axi_bvalid (output, 1) and s_axi_bready (input, 1).
REQ-009 The block SHALL have ports s_axi_araddr (input, 32), s_axi_arvalid (input, 1), s_axi_arready (output, 1) and s_axi_arprot (input, 3); s_axi_arprot is ignored.
REQ-010 The block SHALL have ports s_axi_rdata (output, 32), s_axi_rresp (output, 2), s_axi_rvalid (output, 1) and s_axi_rready (input, 1).
REQ-011 The block SHALL have port regs_o, output, 32*NUM_REGS bits: live register contents, with register k at [32k+:32].

Function
REQ-012 Handshake rule: a channel transfer SHALL occur on a rising edge where valid and ready are both 1.
REQ-013 Address decode: index = addr[2+:clog2(NUM_REGS)], with addr[1:0] ignored; the address SHALL be in range if and only if addr < 4*NUM_REGS, unsigned.
REQ-014 The write side SHALL hold two independent capture flags, aw_held and w_held, plus state W_IDLE or W_RESP.
REQ-015 s_axi_awready SHALL be 1 if and only if aw_held=0 and the write state is W_IDLE; s_axi_wready SHALL be 1 if and only if w_held=0 and the state is W_IDLE.
REQ-016 An AW handshake SHALL latch awaddr and set aw_held; a W handshake SHALL latch wdata and wstrb and set w_held; AW and W may arrive in any order or in the same cycle.
REQ-017 Commit SHALL occur on the edge where the second of AW and W completes, or where both complete together; at that edge the block SHALL:
- write every byte lane with strobe 1 if the address is in range;
- clear both flags;
- enter W_RESP with s_axi_bvalid=1 in the following cycle.
REQ-018 s_axi_bresp SHALL be 2'b00 (OKAY) for an in-range write; for an out-of-range write no register changes and s_axi_bresp SHALL be 2'b10 (SLVERR).
REQ-019 A write with wstrb=4'b0000 that is in range SHALL respond OKAY and leave the register unchanged.
REQ-020 In W_RESP, s_axi_bvalid and s_axi_bresp SHALL hold until s_axi_bready=1, and that edge SHALL return the write side to W_IDLE.
REQ-021 Minimum write throughput SHALL be one write per 2 cycles when s_axi_bready is held at 1.
REQ-022 The read side SHALL have states R_IDLE and R_DATA; s_axi_arready SHALL equal 1 if and only if the read state is R_IDLE.
REQ-023 An AR handshake SHALL capture the addressed register into s_axi_rdata and enter R_DATA, with s_axi_rvalid=1 in the next cycle.
REQ-024 s_axi_rresp SHALL be 2'b00 for an in-range read; an out-of-range read SHALL return s_axi_rdata=0 and s_axi_rresp=2'b10.
REQ-025 In R_DATA, s_axi_rdata, s_axi_rresp and s_axi_rvalid SHALL hold stable until s_axi_rready=1, and that edge SHALL return the read side to R_IDLE.
REQ-026 The read and write sides SHALL be fully independent and may be active in the same cycle.
REQ-027 If an AR handshake and a write commit to the same register occur on the same edge, the read SHALL return the pre-write value.
REQ-028 No output SHALL depend combinationally on any valid or ready input.

Reset
REQ-029 On s_axi_aresetn=0 the block SHALL immediately, independent of the clock, force:
- every register to RESET_VALUE;
- aw_held=0, w_held=0, W_IDLE, R_IDLE;
- s_axi_bvalid=0, s_axi_rvalid=0, s_axi_bresp=0, s_axi_rresp=0, s_axi_rdata=0;
- awready=wready=arready=1 as derived from state.
REQ-030 A reset mid-transaction SHALL discard any half-captured write and any pending response, with no register update.
REQ-031 Operation SHALL resume on the first rising edge after reset is released.

Verification
REQ-032 The bench SHALL cover: AW(0x08) and W(0xDEADBEEF, strb 4'hF) in the same cycle -> bvalid=1 next cycle with bresp=00; regs_o[95:64]=0xDEADBEEF.
REQ-033 The bench SHALL cover: W(0x000000AA, strb 4'b0001) three cycles before AW(0x08), with 0x08 already holding 0xDEADBEEF -> wready=0 while waiting; after AW, reg2=0xDEADBEAA with bresp=00.
REQ-034 The bench SHALL cover: write to 0x40 with NUM_REGS=16 -> bresp=10, all regs unchanged; read from 0x40 -> rdata=0, rresp=10.
REQ-035 The bench SHALL cover: a read of 0x08 with rready held 0 for 5 cycles -> rvalid and rdata stable throughout, arready=0 until the cycle after rready=1.
REQ-036 The bench SHALL cover: AR(0x0C) on the same edge as a write commit of 0x12345678 to 0x0C, with 0x0C previously 0 -> rdata=0; a following read returns 0x12345678.
REQ-037 The bench SHALL cover: aresetn pulsed low after AW only -> bvalid=0, all readies=1, regs=RESET_VALUE; a subsequent W alone produces no bvalid.
